// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - segmented-carry pipelined adder/subtractor with valid/ready handshake
//
// Purpose: computes a + b + cin (add) or a + ~b + ~cin (subtract) over STAGES
// pipeline stages. Stage k resolves result bits [k*SEG +: SEG] from the carry
// registered by stage k-1. Operand bits that are not yet consumed travel along
// in registers. The pipeline moves as one unit: all stages shift when the
// output slot is empty or being taken, and all stages hold otherwise.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - synchronous active-high reset
//   in_valid   - operands present
//   in_ready   - operands accepted this cycle
//   a, b       - operands (WIDTH bits)
//   cin        - carry-in (add) / borrow-in (sub)
//   sub        - 0 = add, 1 = subtract
//   out_valid  - result present
//   out_ready  - downstream accepts result
//   sum        - result (WIDTH bits)
//   cout       - carry out of MSB (for subtract: 1 = no borrow)
//   ovf        - two's-complement signed overflow
//   ovf_count  - saturating count of delivered results with ovf=1
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [15:0]      ovf_count
);

  // Guarded copies so the width arithmetic stays defined while the
  // legality check below reports an illegal configuration.
  localparam int STG = (STAGES < 1) ? 1 : STAGES;
  localparam int SEG = ((WIDTH / STG) < 1) ? 1 : (WIDTH / STG);

  if (STAGES < 1 || WIDTH < 2 || (WIDTH % STG) != 0) begin : g_bad_params
    $error("pipe_adder: illegal parameters (need STAGES>=1, WIDTH>=2, WIDTH %% STAGES == 0)");
  end

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI = (k + 1) * SEG;

    // Registered state of this stage
    logic          v;
    logic [HI-1:0] s;
    logic          c;

    // Inputs to this stage's segment adder
    logic           prev_v;
    logic           sub_k;
    logic           cin_k;
    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic [SEG:0]   seg_sum;
    logic [HI-1:0]  s_next;

    if (k == 0) begin : g_src
      // For subtract the borrow-in becomes carry-in ~cin and b is inverted.
      assign prev_v = in_valid;
      assign sub_k  = sub;
      assign cin_k  = cin ^ sub;
      assign a_seg  = a[SEG-1:0];
      assign b_seg  = b[SEG-1:0] ^ {SEG{sub}};
      assign s_next = seg_sum[SEG-1:0];
    end else begin : g_src
      assign prev_v = g_stage[k-1].v;
      assign sub_k  = g_stage[k-1].g_ops.sb;
      assign cin_k  = g_stage[k-1].c;
      assign a_seg  = g_stage[k-1].g_ops.a_rem[SEG-1:0];
      assign b_seg  = g_stage[k-1].g_ops.b_rem[SEG-1:0] ^ {SEG{sub_k}};
      assign s_next = {seg_sum[SEG-1:0], g_stage[k-1].s};
    end

    assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, cin_k};

    // Data only loads behind a valid entry, so bubbles never disturb the
    // last delivered result sitting in the output stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        v <= 1'b0;
        s <= '0;
        c <= 1'b0;
      end else if (advance) begin
        v <= prev_v;
        if (prev_v) begin
          s <= s_next;
          c <= seg_sum[SEG];
        end
      end
    end

    if (k < STAGES - 1) begin : g_ops
      localparam int REM = WIDTH - HI;

      logic [REM-1:0] a_rem;
      logic [REM-1:0] b_rem;
      logic           sb;
      logic [REM-1:0] a_nxt;
      logic [REM-1:0] b_nxt;

      if (k == 0) begin : g_first
        assign a_nxt = a[WIDTH-1:HI];
        assign b_nxt = b[WIDTH-1:HI];
      end else begin : g_first
        assign a_nxt = g_stage[k-1].g_ops.a_rem[REM+SEG-1:SEG];
        assign b_nxt = g_stage[k-1].g_ops.b_rem[REM+SEG-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem <= '0;
          b_rem <= '0;
          sb    <= 1'b0;
        end else if (advance && prev_v) begin
          a_rem <= a_nxt;
          b_rem <= b_nxt;
          sb    <= sub_k;
        end
      end
    end else begin : g_out
      // Carry into the MSB is a^b^s at that bit; xor with carry out gives ovf.
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance && prev_v) begin
          ovf_q <= a_seg[SEG-1] ^ b_seg[SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v;
  assign sum       = g_stage[STAGES-1].s;
  assign cout      = g_stage[STAGES-1].c;
  assign ovf       = g_stage[STAGES-1].g_out.ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && ovf && ovf_count != 16'hFFFF) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder (WIDTH=16, STAGES=4)
module tb_pipe_adder;
  localparam int W = 16;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic [15:0]   ovf_count;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .ovf_count (ovf_count)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t exp_q[$];   // accepted, not yet delivered (model results)
  res_t dq[$];      // model results of delivered transactions, in order
  res_t got_q[$];   // observed delivered results, in order
  int   errors   = 0;
  int   checks   = 0;
  int   exp_cnt  = 0;
  int   spurious = 0;

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    int   sx, sy, r, u;
    res_t t;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      u   = int'(x) + int'(y) + int'(ci);
      r   = sx + sy + int'(ci);
      t.c = (u > 65535);
    end else begin
      u   = int'(x) - int'(y) - int'(ci);
      r   = sx - sy - int'(ci);
      t.c = (u >= 0);
    end
    t.s = u[15:0];
    t.o = (r > 32767) || (r < -32768);
    return t;
  endfunction

  // One clock: sample handshakes at negedge, then step past the rising edge.
  task automatic tick();
    res_t e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        got_q.push_back({sum, cout, ovf});
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          dq.push_back(e);
          if (e.o && exp_cnt < 65535) exp_cnt++;
        end else begin
          spurious++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (ovf_count !== 16'h0000) begin errors++; $display("FAIL reset_ovf_count: got %h expected 0000", ovf_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0007};
    logic [15:0] tb_[4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0005};
    logic        tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [4] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h0001};
    logic        ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got_q.delete(); dq.delete();
      a = ta[i]; b = tb_[i]; cin = tc[i]; sub = ts[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = ~ts[i];
      n = 1;
      while (got_q.size() == 0 && n < 20) begin tick(); n++; end
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL dir_latency[%0d]: no result within %0d cycles, expected %0d", i, n, S);
      end else begin
        if (n - 1 != S) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, n - 1, S); end
        checks++; if (got_q[0].s !== es[i]) begin errors++; $display("FAIL dir_sum[%0d]: got %h expected %h", i, got_q[0].s, es[i]); end
        checks++; if (got_q[0].c !== ec[i]) begin errors++; $display("FAIL dir_cout[%0d]: got %b expected %b", i, got_q[0].c, ec[i]); end
        checks++; if (got_q[0].o !== eo[i]) begin errors++; $display("FAIL dir_ovf[%0d]: got %b expected %b", i, got_q[0].o, eo[i]); end
      end
    end
    checks++; if (ovf_count !== 16'd1) begin errors++; $display("FAIL dir_ovf_count: got %0d expected 1", ovf_count); end
  endtask

  task automatic test_back_to_back();
    int   sent, stall, n;
    logic pre;
    res_t held;
    got_q.delete(); dq.delete();
    sent = 0; stall = 0; n = 0; held = '0;
    out_ready = 1'b1;
    while (got_q.size() < 8 && n < 200) begin
      in_valid = (sent < 8); a = 16'(sent); b = 16'(sent); cin = 1'b0; sub = 1'b0;
      if (out_valid && stall < 3) begin
        out_ready = 1'b0;
        #1;
        if (stall == 0) held = {sum, cout, ovf};
        else begin
          checks++; if ({sum, cout, ovf} !== held) begin errors++; $display("FAIL b2b_hold[%0d]: got %h expected %h", stall, {sum, cout, ovf}, held); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 0", stall, in_ready); end
        stall++;
      end else begin
        out_ready = 1'b1;
        #1;
        if (stall == 3) begin
          checks++; if ({sum, cout, ovf} !== held) begin errors++; $display("FAIL b2b_hold_release: got %h expected %h", {sum, cout, ovf}, held); end
          stall = 4;
        end
      end
      pre = in_valid && in_ready;
      tick();
      if (pre) sent++;
      n++;
    end
    checks++; if (got_q.size() != 8 || stall != 4) begin errors++; $display("FAIL b2b_count: got %0d results stall %0d expected 8 results stall 4", got_q.size(), stall); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {16'(2 * i), 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, got_q[i], {16'(2 * i), 1'b0, 1'b0}); end
    end
  endtask

  task automatic test_random();
    int n;
    got_q.delete(); dq.delete(); spurious = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a   = (($urandom % 5) == 0) ? 16'h7FFF : 16'($urandom);
      b   = (($urandom % 5) == 0) ? 16'h8000 : 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin tick(); n++; end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain: %0d results still pending expected 0", exp_q.size()); end
    checks++; if (spurious != 0 || got_q.size() != dq.size()) begin errors++; $display("FAIL rnd_count: got %0d results (%0d extra) expected %0d", got_q.size(), spurious, dq.size()); end
    for (int i = 0; i < got_q.size() && i < dq.size(); i++) begin
      checks++;
      if (got_q[i] !== dq[i]) begin errors++; $display("FAIL rnd_result[%0d]: got %h expected %h", i, got_q[i], dq[i]); end
    end
    checks++; if (int'(ovf_count) != exp_cnt) begin errors++; $display("FAIL rnd_ovf_count: got %0d expected %0d", ovf_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); dq.delete(); spurious = 0;
    out_ready = 1'b1;
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    repeat (10) tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_stale: got %0d results expected 0", got_q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid_later: got %b expected 0", out_valid); end
    checks++; if (ovf_count !== 16'h0000) begin errors++; $display("FAIL mid_ovf_count: got %0d expected 0", ovf_count); end
  endtask

  task automatic test_saturation();
    int n;
    bit mid_done;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    got_q.delete(); dq.delete(); spurious = 0;
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    n = 0; mid_done = 1'b0;
    while (got_q.size() < 65537 && n < 70000) begin
      in_valid = (got_q.size() + exp_q.size()) < 65537;
      tick();
      n++;
      if (!mid_done && got_q.size() == 65534) begin
        mid_done = 1'b1;
        checks++; if (ovf_count !== 16'd65534) begin errors++; $display("FAIL sat_mid: got %0d expected 65534", ovf_count); end
      end
    end
    in_valid = 1'b0;
    checks++; if (got_q.size() != 65537 || !mid_done) begin errors++; $display("FAIL sat_delivered: got %0d expected 65537", got_q.size()); end
    checks++; if (ovf_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %h expected ffff", ovf_count); end
    checks++; if (spurious != 0) begin errors++; $display("FAIL sat_extra: got %0d extra results expected 0", spurious); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter: STAGES, default 4, number of pipeline stages; the carry chain is split into STAGES equal segments.
REQ-003 Parameter legality: STAGES >= 1, WIDTH >= 2, WIDTH % STAGES == 0; the block SHALL fail elaboration otherwise.
REQ-004 Port: clk  in  1  single clock, all state on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: in_valid  in  1  input operands present.
REQ-007 Port: in_ready  out  1  block accepts operands this cycle.
REQ-008 Port: a  in  WIDTH  operand A.
REQ-009 Port: b  in  WIDTH  operand B.
REQ-010 Port: cin  in  1  carry-in (add) / borrow-in (sub).
REQ-011 Port: sub  in  1  0 = add, 1 = subtract.
REQ-012 Port: out_valid  out  1  result present.
REQ-013 Port: out_ready  in  1  downstream accepts result.
REQ-014 Port: sum  out  WIDTH  result.
REQ-015 Port: cout  out  1  carry out of MSB.
REQ-016 Port: ovf  out  1  two's-complement signed overflow.
REQ-017 Port: ovf_count  out  16  saturating count of delivered results with ovf=1.

Function
REQ-018 Add: {cout,sum} SHALL equal a + b + cin, computed at WIDTH+1 bits.
REQ-019 Sub: {cout,sum} SHALL equal a + ~b + ~cin, i.e. sum = a - b - cin mod 2^WIDTH; cout=1 means no borrow.
REQ-020 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-021 Stage k (0..STAGES-1) SHALL compute bits [k*W/S +: W/S] from that stage's registered carry-in; operand bits above that segment SHALL be delayed in registers; no combinational path spans more than one segment.
REQ-022 Each stage SHALL hold a valid bit; stage results, operand slices, sub and carry SHALL advance together.
REQ-023 Global advance = !out_valid || out_ready; when advance=1 every stage shifts one step, otherwise all stages hold.
REQ-024 in_ready SHALL equal advance; a transfer occurs when in_valid && in_ready.
REQ-025 Stage 0 valid SHALL load in_valid && in_ready on advance; non-transfer cycles SHALL insert a bubble.
REQ-026 Latency: a transfer at edge N SHALL produce out_valid=1 with its result after edge N+STAGES-1 (visible STAGES cycles after the accept cycle), when no stall occurs.
REQ-027 Results SHALL emerge in acceptance order; none lost or duplicated.
REQ-028 While out_valid && !out_ready, sum, cout and ovf SHALL hold stable.
REQ-029 Internal bubbles are not collapsed during a stall; throughput is one result per cycle when out_ready=1.
REQ-030 ovf_count SHALL increment on each output transfer (out_valid && out_ready) with ovf=1, saturating at 0xFFFF.
REQ-031 STAGES=1: single registered stage, latency 1, same handshake rules.
REQ-032 Operands, sub and cin SHALL be sampled only on a transfer; values on non-transfer cycles SHALL have no effect.

Reset
REQ-033 rst=1 at an edge SHALL clear all stage valid bits; out_valid=0 after that edge.
REQ-034 After reset, sum=0, cout=0, ovf=0, ovf_count=0.
REQ-035 Reset mid-operation SHALL discard all in-flight transactions; none emerge afterwards.
REQ-036 in_ready SHALL be 1 in the first cycle after reset is released.

Verification (WIDTH=16, STAGES=4)
REQ-037 Add 0xFFFF+0x0001, cin=0, out_ready=1 -> after 4 cycles out_valid=1, sum=0x0000, cout=1, ovf=0.
REQ-038 Add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; ovf_count becomes 1 on delivery.
REQ-039 Sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; sub 0x0007-0x0005, cin=1 -> sum=0x0001, cout=1.
REQ-040 8 back-to-back adds (a=i, b=i) with out_ready=0 for 3 cycles once the first result appears -> in_ready=0 during the stall, outputs held, sums 0,2,...,14 delivered in order.
REQ-041 Accept 3 transactions, assert rst for 1 cycle -> out_valid=0 thereafter, no stale result appears, ovf_count=0.
REQ-042 Force 65537 overflowing results (0x7FFF+0x0001) -> ovf_count saturates at 0xFFFF.
